// File: rtl/lc3b_types.sv
// Shared LC-3b pipeline types: control word, memory-op and memory-stage state encodings,
// plus small decode helpers used by the memory stage.
package lc3b_types;

    typedef struct packed {
        logic       load_regfile;
        logic       load_cc;
        logic [1:0] regfile_mux_sel;
        logic [3:0] aluop;
    } lc3b_control;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        LDR  = 3'd1,
        STR  = 3'd2,
        LDB  = 3'd3,
        STB  = 3'd4,
        LDI  = 3'd5,
        STI  = 3'd6
    } lc3b_memop;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM1 = 2'd1,
        MEM2 = 2'd2
    } lc3b_memstate;

    function automatic logic is_mem_op(input lc3b_memop op);
        return op inside {LDR, STR, LDB, STB, LDI, STI};
    endfunction

    function automatic logic is_word_op(input lc3b_memop op);
        return op inside {LDR, STR, LDI, STI};
    endfunction

    // STI reads its pointer first, so it starts as a read like the loads
    function automatic logic is_first_read(input lc3b_memop op);
        return op inside {LDR, LDB, LDI, STI};
    endfunction

    function automatic logic [15:0] word_align(input logic [15:0] addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/mem_access_module_lane_align.sv
// Byte-lane handling for the memory stage: store byte-enable / write-data replication
// and LDB byte select with sign extension.
module mem_lane_align
    import lc3b_types::*;
(
    input  lc3b_memop   st_op,
    input  logic [15:0] st_addr,
    input  logic [15:0] st_data,
    input  logic [15:0] ld_rdata,
    input  logic        ld_hi,
    output logic [1:0]  byte_enable,
    output logic [15:0] wdata,
    output logic [15:0] ldb_data
);

    logic [7:0] byte_sel_s;

    // Store lanes: STB replicates the byte onto both lanes and enables only the addressed one
    always_comb begin
        byte_enable = 2'b11;
        wdata       = st_data;
        if (st_op == STB) begin
            byte_enable = st_addr[0] ? 2'b10 : 2'b01;
            wdata       = {st_data[7:0], st_data[7:0]};
        end else begin
            byte_enable = 2'b11;
            wdata       = st_data;
        end
    end

    // Load byte select and sign extension
    always_comb begin
        byte_sel_s = ld_hi ? ld_rdata[15:8] : ld_rdata[7:0];
        ldb_data   = {{8{byte_sel_s[7]}}, byte_sel_s};
    end

endmodule

// File: rtl/mem_access_module.sv
// LC-3b memory stage: one data-cache access per instruction (two for LDI/STI), MEM/WB register.
// Optional MEMSTAGE_PERF_EN adds saturating access and stall counters.
module mem_access_module
    import lc3b_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  lc3b_memop   in_memop,
    input  lc3b_control in_ctrl,
    input  logic [15:0] in_alu,
    input  logic [15:0] in_sdata,
    input  logic [15:0] in_ir,
    input  logic [15:0] in_pc,
    output logic [15:0] dmem_address,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        out_valid,
    output logic [15:0] alu_out,
    output logic [15:0] mdr_out,
    output logic [15:0] ir_out,
    output logic [15:0] pc_out,
    output lc3b_control ctrl_out,
    output logic [15:0] cc_data_out
`ifdef MEMSTAGE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_accesses,
    output logic [CNT_W-1:0] perf_stall_cycles
`endif
);

    lc3b_memstate state_r;
    lc3b_memop    memop_r;
    lc3b_control  ctrl_r;
    logic [15:0]  alu_r, sdata_r, ir_r, pc_r, mdr_r, cc_r;
    logic [15:0]  addr_r, wdata_r;
    logic [1:0]   be_r;
    logic         read_r, write_r, out_valid_r;
    logic [1:0]   st_be_s;
    logic [15:0]  st_wdata_s, ldb_data_s;

    mem_lane_align u_lane_align (
        .st_op       (in_memop),
        .st_addr     (in_alu),
        .st_data     (in_sdata),
        .ld_rdata    (dmem_rdata),
        .ld_hi       (addr_r[0]),
        .byte_enable (st_be_s),
        .wdata       (st_wdata_s),
        .ldb_data    (ldb_data_s)
    );

    assign in_ready         = (state_r == IDLE) && !reset;
    assign dmem_address     = addr_r;
    assign dmem_read        = read_r;
    assign dmem_write       = write_r;
    assign dmem_byte_enable = be_r;
    assign dmem_wdata       = wdata_r;
    assign out_valid        = out_valid_r;
    assign alu_out          = alu_r;
    assign mdr_out          = mdr_r;
    assign ir_out           = ir_r;
    assign pc_out           = pc_r;
    assign ctrl_out         = ctrl_r;
    assign cc_data_out      = cc_r;

    // Memory-stage FSM; bus strobes are registered so reset drops them asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            memop_r     <= NONE;
            ctrl_r      <= '0;
            alu_r       <= 16'h0000;
            sdata_r     <= 16'h0000;
            ir_r        <= 16'h0000;
            pc_r        <= 16'h0000;
            mdr_r       <= 16'h0000;
            cc_r        <= 16'h0000;
            addr_r      <= 16'h0000;
            wdata_r     <= 16'h0000;
            be_r        <= 2'b00;
            read_r      <= 1'b0;
            write_r     <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        memop_r <= in_memop;
                        ctrl_r  <= in_ctrl;
                        alu_r   <= in_alu;
                        sdata_r <= in_sdata;
                        ir_r    <= in_ir;
                        pc_r    <= in_pc;
                        if (is_mem_op(in_memop)) begin
                            state_r <= MEM1;
                            addr_r  <= is_word_op(in_memop) ? word_align(in_alu) : in_alu;
                            read_r  <= is_first_read(in_memop);
                            write_r <= !is_first_read(in_memop);
                            be_r    <= st_be_s;
                            wdata_r <= st_wdata_s;
                        end else begin
                            out_valid_r <= 1'b1;
                            cc_r        <= in_alu;
                        end
                    end
                end
                MEM1: begin
                    if (dmem_resp) begin
                        case (memop_r)
                            LDI, STI: begin
                                // first access returned the pointer; second access follows
                                state_r <= MEM2;
                                addr_r  <= word_align(dmem_rdata);
                                read_r  <= (memop_r == LDI);
                                write_r <= (memop_r == STI);
                                be_r    <= 2'b11;
                                wdata_r <= sdata_r;
                            end
                            LDR: begin
                                mdr_r <= dmem_rdata;
                                cc_r  <= dmem_rdata;
                            end
                            LDB: begin
                                mdr_r <= ldb_data_s;
                                cc_r  <= ldb_data_s;
                            end
                            default: begin
                                cc_r <= alu_r;
                            end
                        endcase
                        if (memop_r != LDI && memop_r != STI) begin
                            state_r     <= IDLE;
                            read_r      <= 1'b0;
                            write_r     <= 1'b0;
                            out_valid_r <= 1'b1;
                        end
                    end
                end
                MEM2: begin
                    if (dmem_resp) begin
                        if (memop_r == LDI) begin
                            mdr_r <= dmem_rdata;
                            cc_r  <= dmem_rdata;
                        end else begin
                            cc_r <= alu_r;
                        end
                        state_r     <= IDLE;
                        read_r      <= 1'b0;
                        write_r     <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    read_r  <= 1'b0;
                    write_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEMSTAGE_PERF_EN
    logic [CNT_W-1:0] perf_acc_r, perf_stall_r;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign perf_accesses     = perf_acc_r;
    assign perf_stall_cycles = perf_stall_r;

    // Saturating access / stall counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_acc_r   <= '0;
            perf_stall_r <= '0;
        end else if (state_r == MEM1 || state_r == MEM2) begin
            if (dmem_resp) begin
                if (perf_acc_r != '1) perf_acc_r <= perf_acc_r + CNT_ONE;
            end else begin
                if (perf_stall_r != '1) perf_stall_r <= perf_stall_r + CNT_ONE;
            end
        end
    end
`else
    // keeps CNT_W referenced when the counters are compiled out
    logic [CNT_W-1:0] perf_unused_s;
    assign perf_unused_s = '0;
`endif

endmodule

// File: tb/tb_mem_access_module.sv
// Self-checking bench for mem_access_module: directed cases plus randomized back-to-back
// traffic checked against a word-addressed memory model.
module tb_mem_access_module;
    import lc3b_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    lc3b_memop   in_memop;
    lc3b_control in_ctrl;
    logic [15:0] in_alu, in_sdata, in_ir, in_pc;
    logic [15:0] dmem_address, dmem_wdata, dmem_rdata;
    logic        dmem_read, dmem_write, dmem_resp;
    logic [1:0]  dmem_byte_enable;
    logic        out_valid;
    logic [15:0] alu_out, mdr_out, ir_out, pc_out, cc_data_out;
    lc3b_control ctrl_out;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] mem [logic [15:0]];
    logic [15:0] exp_mdr;

    typedef struct {
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    mem_access_module dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_memop(in_memop), .in_ctrl(in_ctrl), .in_alu(in_alu), .in_sdata(in_sdata),
        .in_ir(in_ir), .in_pc(in_pc), .dmem_address(dmem_address), .dmem_read(dmem_read),
        .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .out_valid(out_valid),
        .alu_out(alu_out), .mdr_out(mdr_out), .ir_out(ir_out), .pc_out(pc_out),
        .ctrl_out(ctrl_out), .cc_data_out(cc_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [15:0] a);
        logic [15:0] w;
        w = a & 16'hFFFE;
        if (mem.exists(w)) return mem[w];
        return w ^ 16'hC3A5;
    endfunction

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return (b >= 8'h80) ? (16'hFF00 + {8'h00, b}) : {8'h00, b};
    endfunction

    task automatic mem_store_byte(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] w;
        w = mem_rd(a);
        if (a % 16'd2 == 16'd1) w = {b, w[7:0]};
        else w = {w[15:8], b};
        mem[a & 16'hFFFE] = w;
    endtask

    // Issue one instruction (caller is at a negedge), serve its accesses, check the MEM/WB result
    task automatic do_txn(input lc3b_memop op, input logic [15:0] alu, input logic [15:0] sdata,
                          input int lat);
        acc_t        acc[2];
        int          n;
        logic [15:0] ptr, exp_cc, ir, pc;
        lc3b_control ctrl;
        ir   = 16'($urandom);
        pc   = 16'($urandom);
        ctrl = lc3b_control'(8'($urandom));
        n    = 0;
        ptr  = mem_rd(alu) & 16'hFFFE;
        case (op)
            LDR: begin acc[0] = '{alu & 16'hFFFE, 1'b1, 1'b0, 2'b11, 16'h0}; n = 1; end
            LDB: begin acc[0] = '{alu, 1'b1, 1'b0, 2'b11, 16'h0}; n = 1; end
            STR: begin acc[0] = '{alu & 16'hFFFE, 1'b0, 1'b1, 2'b11, sdata}; n = 1; end
            STB: begin
                acc[0] = '{alu, 1'b0, 1'b1, (alu % 16'd2 == 16'd1) ? 2'b10 : 2'b01,
                           {sdata[7:0], sdata[7:0]}};
                n = 1;
            end
            LDI: begin
                acc[0] = '{alu & 16'hFFFE, 1'b1, 1'b0, 2'b11, 16'h0};
                acc[1] = '{ptr, 1'b1, 1'b0, 2'b11, 16'h0};
                n = 2;
            end
            STI: begin
                acc[0] = '{alu & 16'hFFFE, 1'b1, 1'b0, 2'b11, 16'h0};
                acc[1] = '{ptr, 1'b0, 1'b1, 2'b11, sdata};
                n = 2;
            end
            default: n = 0;
        endcase
        case (op)
            LDR: exp_mdr = mem_rd(alu);
            LDB: exp_mdr = (alu % 16'd2 == 16'd1) ? sext8(mem_rd(alu) >> 8) : sext8(mem_rd(alu) % 16'd256);
            LDI: exp_mdr = mem_rd(ptr);
            default: ;
        endcase
        exp_cc = (op == LDR || op == LDB || op == LDI) ? exp_mdr : alu;

        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_before_issue: got %b expected 1", in_ready);
        end
        in_valid = 1'b1; in_memop = op; in_alu = alu; in_sdata = sdata;
        in_ir = ir; in_pc = pc; in_ctrl = ctrl;
        @(negedge clk);
        if (n > 0) begin
            // garbage held on the inputs while busy must be neither accepted nor used
            in_memop = lc3b_memop'(3'($urandom)); in_alu = 16'($urandom);
            in_sdata = 16'($urandom); in_ir = 16'($urandom); in_pc = 16'($urandom);
            in_ctrl = lc3b_control'(8'($urandom));
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 0; k < n; k++) begin
            int l;
            l = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
            for (int c = 0; c <= l; c++) begin
                n_checks++;
                if (dmem_read !== acc[k].rd || dmem_write !== acc[k].wr ||
                    dmem_address !== acc[k].addr || in_ready !== 1'b0 || out_valid !== 1'b0 ||
                    (acc[k].wr && (dmem_byte_enable !== acc[k].be || dmem_wdata !== acc[k].wdata))) begin
                    n_errors++;
                    $display("FAIL bus_%s_acc%0d_cyc%0d: got rd=%b wr=%b addr=%h be=%b wd=%h rdy=%b ov=%b expected rd=%b wr=%b addr=%h be=%b wd=%h rdy=0 ov=0",
                             op.name(), k, c, dmem_read, dmem_write, dmem_address, dmem_byte_enable,
                             dmem_wdata, in_ready, out_valid, acc[k].rd, acc[k].wr, acc[k].addr,
                             acc[k].be, acc[k].wdata);
                end
                if (c == l) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = acc[k].rd ? mem_rd(acc[k].addr) : 16'($urandom);
                    if (k == n - 1) in_valid = 1'b0;
                end
                @(negedge clk);
                dmem_resp  = 1'b0;
                dmem_rdata = 16'($urandom);
            end
        end
        if (op == STR || op == STI) mem[acc[n-1].addr] = sdata;
        if (op == STB) mem_store_byte(alu, sdata[7:0]);

        n_checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || dmem_read !== 1'b0 || dmem_write !== 1'b0) begin
            n_errors++;
            $display("FAIL done_%s: got ov=%b rdy=%b rd=%b wr=%b expected ov=1 rdy=1 rd=0 wr=0",
                     op.name(), out_valid, in_ready, dmem_read, dmem_write);
        end
        n_checks++;
        if (alu_out !== alu || ir_out !== ir || pc_out !== pc || ctrl_out !== ctrl) begin
            n_errors++;
            $display("FAIL passthru_%s: got alu=%h ir=%h pc=%h ctrl=%h expected alu=%h ir=%h pc=%h ctrl=%h",
                     op.name(), alu_out, ir_out, pc_out, ctrl_out, alu, ir, pc, ctrl);
        end
        n_checks++;
        if (mdr_out !== exp_mdr || cc_data_out !== exp_cc) begin
            n_errors++;
            $display("FAIL result_%s: got mdr=%h cc=%h expected mdr=%h cc=%h",
                     op.name(), mdr_out, cc_data_out, exp_mdr, exp_cc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_memop = NONE; in_ctrl = '0; in_alu = 16'h0;
        in_sdata = 16'h0; in_ir = 16'h0; in_pc = 16'h0; dmem_rdata = 16'h0; dmem_resp = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || dmem_read !== 1'b0 || dmem_write !== 1'b0 ||
            alu_out !== 16'h0 || mdr_out !== 16'h0 || ir_out !== 16'h0 || pc_out !== 16'h0 ||
            ctrl_out !== 8'h00 || cc_data_out !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_state: got rdy=%b ov=%b rd=%b wr=%b alu=%h mdr=%h ir=%h pc=%h cc=%h expected all 0",
                     in_ready, out_valid, dmem_read, dmem_write, alu_out, mdr_out, ir_out, pc_out, cc_data_out);
        end
        reset = 1'b0;
        exp_mdr = 16'h0;
        @(negedge clk);
    endtask

    task automatic test_none();
        do_txn(NONE, 16'h1234, 16'h5555, 0);
        n_checks++;
        if (alu_out !== 16'h1234 || cc_data_out !== 16'h1234) begin
            n_errors++;
            $display("FAIL none_values: got alu=%h cc=%h expected 1234 1234", alu_out, cc_data_out);
        end
    endtask

    task automatic test_ldr();
        mem[16'h3000] = 16'hBEEF;
        do_txn(LDR, 16'h3001, 16'h0000, 2);
        n_checks++;
        if (mdr_out !== 16'hBEEF) begin
            n_errors++;
            $display("FAIL ldr_value: got %h expected beef", mdr_out);
        end
    endtask

    task automatic test_byte_ops();
        do_txn(STB, 16'h4005, 16'h00A7, 1);
        mem[16'h4004] = 16'h1280;
        do_txn(LDB, 16'h4004, 16'h0000, 0);
        n_checks++;
        if (mdr_out !== 16'hFF80) begin
            n_errors++;
            $display("FAIL ldb_value: got %h expected ff80", mdr_out);
        end
        do_txn(LDB, 16'h4005, 16'h0000, 3);
    endtask

    task automatic test_indirect();
        mem[16'h5000] = 16'h6000;
        mem[16'h6000] = 16'h0042;
        do_txn(LDI, 16'h5000, 16'h0000, 1);
        n_checks++;
        if (mdr_out !== 16'h0042) begin
            n_errors++;
            $display("FAIL ldi_value: got %h expected 0042", mdr_out);
        end
        mem[16'h5100] = 16'h7001;
        do_txn(STI, 16'h5100, 16'hCAFE, 0);
        do_txn(LDR, 16'h7000, 16'h0000, 0);
        do_txn(LDR, 16'hFFFF, 16'h0000, 1);
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_memop = LDR; in_alu = 16'h7002;
        @(negedge clk);
        in_valid = 1'b0;
        n_checks++;
        if (dmem_read !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_reset_pre: got rd=%b expected 1", dmem_read);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (dmem_read !== 1'b0 || dmem_write !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_reset_drop: got rd=%b wr=%b rdy=%b ov=%b expected 0 0 0 0",
                     dmem_read, dmem_write, in_ready, out_valid);
        end
        @(negedge clk);
        reset = 1'b0; exp_mdr = 16'h0;
        dmem_resp = 1'b1; dmem_rdata = 16'hABCD;
        @(negedge clk);
        dmem_resp = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (out_valid !== 1'b0 || mdr_out !== 16'h0 || dmem_read !== 1'b0 || in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL late_resp_cyc%0d: got ov=%b mdr=%h rd=%b rdy=%b expected 0 0000 0 1",
                         c, out_valid, mdr_out, dmem_read, in_ready);
            end
            @(negedge clk);
        end
        do_txn(LDR, 16'h3000, 16'h0000, 0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            lc3b_memop op;
            logic [15:0] a;
            op = lc3b_memop'(3'($urandom_range(0, 6)));
            a  = {4'h8 + 4'($urandom_range(0, 1)), 4'h0, 8'($urandom)};
            if (op == LDI || op == STI) mem[a & 16'hFFFE] = {4'h9, 4'h0, 8'($urandom)};
            do_txn(op, a, 16'($urandom), -1);
        end
    endtask

    initial begin
        test_reset();
        test_none();
        test_ldr();
        test_byte_ops();
        test_indirect();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
